branch_hazard_ctrl: RTL and testbench
=====================================

# branch_hazard_ctrl

- Pipeline hazard sequencer for the 5-stage core.
- Detects conditional branches (beq/bne) and load-use dependencies in ID.
- Drives the PC hold, IF/ID hold, ID/EX bubble and IF/ID flush controls.
- Sequences the freeze until the branch outcome (`branch_mem`) resolves in MEM.

## Interface
- `BR_WAIT`, default 2: bubble cycles between branch detection in ID and resolution in MEM (legal 1..6).
- `REG_W`, default 5: register-specifier width.
- `clk` in 1: pipeline clock; the controller updates on the falling edge.
- `rst` in 1: reset, asynchronous, active-low.
- `opcode_id` in 6: opcode of the instruction in ID.
- `rs_id` in REG_W: source register 1 in ID.
- `rt_id` in REG_W: source register 2 in ID.
- `mem_read_ex` in 1: instruction in EX is a load.
- `rt_ex` in REG_W: destination register of the load in EX.
- `branch_mem` in 1: branch in MEM is taken; valid only in BR_RES.
- `stop_pc` out 1: hold PC.
- `stop_latch` out 1: hold IF/ID.
- `bubble` out 1: zero the ID/EX control fields.
- `flush_if_id` out 1: invalidate the IF/ID contents.
- `take_branch` out 1: PC mux selects the branch target.
- `busy` out 1: state is not IDLE.

## Operation
- `is_branch` = `opcode_id[5:1] == 5'b00010` (beq 000100, bne 000101).
- `load_use` = `mem_read_ex` & (`rt_ex != 0`) & (`rt_ex == rs_id` | `rt_ex == rt_id`).
- States: IDLE, LU_STALL, BR_WAIT_S, BR_RES.
- Wait counter: 3 bits.
- IDLE:
  - `load_use` → LU_STALL.
  - Otherwise `is_branch` → BR_WAIT_S, counter = 0.
  - Load-use has priority: the branch stays held in ID and is re-detected after the stall.
- LU_STALL:
  - Asserts `stop_pc`, `stop_latch`, `bubble` for one cycle.
  - → IDLE.
- BR_WAIT_S:
  - Asserts `stop_pc`, `bubble`.
  - Counter increments each cycle.
  - When counter == BR_WAIT−1 → BR_RES.
- BR_RES:
  - `bubble` stays asserted.
  - `branch_mem` = 1: assert `take_branch` and `flush_if_id`, keep `stop_pc` = 0, → IDLE.
  - `branch_mem` = 0: release all controls, → IDLE.
- Decoding of `is_branch` and `load_use` is ignored in every state except IDLE.
- `branch_mem` is ignored outside BR_RES.
- `busy` = (state != IDLE).

## Timing
- State, counter and all outputs are registered on the falling edge of `clk`; the pipeline latches sample them on the next rising edge.
- Reset (`rst` = 0):
  - State IDLE, counter 0.
  - `stop_pc`, `stop_latch`, `bubble`, `flush_if_id`, `take_branch`, `busy` all 0, immediately and asynchronously.
- Reset mid-sequence: abandons the sequence with no pending flush; after release, the controller re-evaluates from IDLE.
- Load-use latency: detection on falling edge N, stall controls asserted from N to N+1, exactly 1 bubble.
- Branch latency: detection on falling edge N.
  - `stop_pc`/`bubble` asserted for BR_WAIT cycles.
  - Resolution at edge N+BR_WAIT.
  - Total freeze: BR_WAIT+1 cycles.
- Counter wrap is not possible: BR_WAIT ≤ 6 < 8.
- Back-to-back branch: a branch fetched after resolution is detected in IDLE on the next edge; no dead cycle is added.
- `take_branch` and `flush_if_id` are single-cycle pulses.

## Configuration
- `HAZARD_LOAD_USE_EN` defined: load-use detection and LU_STALL are compiled in, as described above.
- Undefined: `load_use` is tied to 0 and LU_STALL is removed. Only branch sequencing remains; load-use hazards are then the forwarding unit's responsibility.

## Structure
- Shared package `pipe_ctrl_pkg`:
  - Opcode constants `OP_BEQ`, `OP_BNE`.
  - State enum `hz_state_t` (2-bit encoding).
  - `REG_W` default.
- Sub-module `load_use_detect` (combinational): `mem_read_ex`, `rt_ex`, `rs_id`, `rt_id` → `load_use`. Instantiated only under `HAZARD_LOAD_USE_EN`.
- Top module holds the FSM, the counter and the output registers.

## Test plan
- Reset: hold `rst` = 0 with random inputs → all outputs 0 and `busy` = 0. Release `rst` → still 0 while `opcode_id` = 6'b000000.
- Load-use: `mem_read_ex` = 1, `rt_ex` = 5, `rs_id` = 5 → `stop_pc`/`stop_latch`/`bubble` high for exactly 1 cycle. Same with `rt_ex` = 0 → no stall.
- Taken branch: `opcode_id` = 6'b000100, BR_WAIT = 2 → `stop_pc` high 2 cycles. `branch_mem` = 1 in BR_RES → `take_branch` and `flush_if_id` pulse 1 cycle; IDLE next cycle.
- Not-taken branch: `opcode_id` = 6'b000101, `branch_mem` = 0 → freeze of 3 cycles total, no `take_branch`/`flush_if_id`. `branch_mem` pulsed during BR_WAIT_S → ignored.
- Priority: branch in ID plus a load-use hit on `rt_id` → 1 LU_STALL cycle, then the branch sequence starts on the following edge.
- Reset mid-sequence: `rst` = 0 during BR_WAIT_S → outputs drop asynchronously; after release, no `take_branch` occurs even with `branch_mem` = 1.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the 5-stage core pipeline control logic:
//   - conditional-branch opcodes (beq / bne)
//   - hazard sequencer state encoding (2-bit)
//   - packed control-output bundle and its canonical values
//   - default register-specifier width
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

  localparam int REG_W_DEFAULT = 5;

  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;

  typedef enum logic [1:0] {
    HZ_IDLE     = 2'b00,
    HZ_LU_STALL = 2'b01,
    HZ_BR_WAIT  = 2'b10,
    HZ_BR_RES   = 2'b11
  } hz_state_t;

  // Registered control outputs, kept together so each FSM arm loads one value.
  typedef struct packed {
    logic stop_pc;
    logic stop_latch;
    logic bubble;
    logic flush_if_id;
    logic take_branch;
    logic busy;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_NONE    = hz_ctrl_t'(6'b000000);
  localparam hz_ctrl_t CTRL_LU      = hz_ctrl_t'(6'b111001);
  localparam hz_ctrl_t CTRL_BR_WAIT = hz_ctrl_t'(6'b101001);
  localparam hz_ctrl_t CTRL_BR_RES  = hz_ctrl_t'(6'b001001);
  // Taken resolution: redirect PC and kill the wrong-path fetch; sequencer is idle again.
  localparam hz_ctrl_t CTRL_TAKEN   = hz_ctrl_t'(6'b000110);

  // beq and bne differ only in opcode bit 0.
  function automatic logic is_cond_branch(input logic [5:0] opcode);
    return (opcode[5:1] == OP_BEQ[5:1]);
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// -----------------------------------------------------------------------------
// load_use_detect
// Combinational load-use hazard detector. Flags when the load currently in EX
// writes a register that the instruction in ID reads. Register 0 is hardwired
// to zero, so a load targeting it never creates a dependency.
// Ports:
//   mem_read_ex  in  1      instruction in EX is a load
//   rt_ex        in  REG_W  destination register of the load in EX
//   rs_id        in  REG_W  source register 1 of the instruction in ID
//   rt_id        in  REG_W  source register 2 of the instruction in ID
//   load_use     out 1      dependency detected
// -----------------------------------------------------------------------------
module load_use_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = REG_W_DEFAULT
) (
  input  logic             mem_read_ex,
  input  logic [REG_W-1:0] rt_ex,
  input  logic [REG_W-1:0] rs_id,
  input  logic [REG_W-1:0] rt_id,
  output logic             load_use
);

  logic dst_nonzero_s;
  logic src_match_s;

  // Compare the load destination against both ID source operands.
  always_comb begin
    dst_nonzero_s = (rt_ex != {REG_W{1'b0}});
    src_match_s   = (rt_ex == rs_id) || (rt_ex == rt_id);
    if (mem_read_ex && dst_nonzero_s && src_match_s) begin
      load_use = 1'b1;
    end else begin
      load_use = 1'b0;
    end
  end

endmodule

// File: rtl/branch_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// branch_hazard_ctrl
// Pipeline hazard sequencer for the 5-stage core. Detects conditional branches
// (beq/bne) and, optionally, load-use dependencies in ID, and drives the PC
// hold, IF/ID hold, ID/EX bubble and IF/ID flush controls until the branch
// outcome resolves in MEM.
//
// The controller updates on the FALLING edge of clk so the pipeline latches
// see stable controls on the following rising edge. All outputs are registered.
//
// Configuration macro: HAZARD_LOAD_USE_EN
//   defined   : load-use detection and the one-cycle LU_STALL are compiled in.
//   undefined : load-use is left to the forwarding unit; branch sequencing only.
//
// Parameters:
//   BR_WAIT  bubble cycles between branch detection in ID and MEM resolution (1..6)
//   REG_W    register-specifier width
// Ports:
//   clk          in  1      pipeline clock (controller uses falling edge)
//   rst          in  1      asynchronous active-low reset
//   opcode_id    in  6      opcode in ID
//   rs_id        in  REG_W  source register 1 in ID
//   rt_id        in  REG_W  source register 2 in ID
//   mem_read_ex  in  1      instruction in EX is a load
//   rt_ex        in  REG_W  load destination in EX
//   branch_mem   in  1      branch in MEM is taken (sampled only in BR_RES)
//   stop_pc      out 1      hold PC
//   stop_latch   out 1      hold IF/ID
//   bubble       out 1      zero ID/EX control fields
//   flush_if_id  out 1      invalidate IF/ID
//   take_branch  out 1      PC mux selects branch target
//   busy         out 1      sequencer not idle
// -----------------------------------------------------------------------------
module branch_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int BR_WAIT = 2,
  parameter int REG_W   = REG_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode_id,
  input  logic [REG_W-1:0] rs_id,
  input  logic [REG_W-1:0] rt_id,
  input  logic             mem_read_ex,
  input  logic [REG_W-1:0] rt_ex,
  input  logic             branch_mem,
  output logic             stop_pc,
  output logic             stop_latch,
  output logic             bubble,
  output logic             flush_if_id,
  output logic             take_branch,
  output logic             busy
);

  // Last counter value spent in BR_WAIT_S; BR_WAIT <= 6 keeps it inside 3 bits.
  localparam logic [2:0] WAIT_LAST = 3'(BR_WAIT - 1);

  hz_state_t  state_r;
  logic [2:0] cnt_r;
  hz_ctrl_t   ctrl_r;

  logic is_branch_s;
  logic load_use_s;
  logic unused_ok_s;

`ifdef HAZARD_LOAD_USE_EN
  load_use_detect #(
    .REG_W (REG_W)
  ) u_load_use_detect (
    .mem_read_ex (mem_read_ex),
    .rt_ex       (rt_ex),
    .rs_id       (rs_id),
    .rt_id       (rt_id),
    .load_use    (load_use_s)
  );

  assign unused_ok_s = opcode_id[0];
`else
  // Load-use is handled by forwarding in this build; operand inputs are not needed.
  assign load_use_s  = 1'b0;
  assign unused_ok_s = ^{opcode_id[0], mem_read_ex, rt_ex, rs_id, rt_id};
`endif

  // ID-stage branch decode.
  always_comb begin
    if (is_cond_branch(opcode_id)) begin
      is_branch_s = 1'b1;
    end else begin
      is_branch_s = 1'b0;
    end
  end

  // Hazard FSM: state, wait counter and registered control outputs.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= HZ_IDLE;
      cnt_r   <= 3'd0;
      ctrl_r  <= CTRL_NONE;
    end else begin
      case (state_r)
        HZ_IDLE: begin
          cnt_r <= 3'd0;
`ifdef HAZARD_LOAD_USE_EN
          // Load-use wins; a branch in ID stays held and is re-detected afterwards.
          if (load_use_s) begin
            state_r <= HZ_LU_STALL;
            ctrl_r  <= CTRL_LU;
          end else
`endif
          if (is_branch_s) begin
            state_r <= HZ_BR_WAIT;
            ctrl_r  <= CTRL_BR_WAIT;
          end else begin
            state_r <= HZ_IDLE;
            ctrl_r  <= CTRL_NONE;
          end
        end

`ifdef HAZARD_LOAD_USE_EN
        HZ_LU_STALL: begin
          state_r <= HZ_IDLE;
          cnt_r   <= 3'd0;
          ctrl_r  <= CTRL_NONE;
        end
`endif

        HZ_BR_WAIT: begin
          if (cnt_r == WAIT_LAST) begin
            // PC hold drops here; only the bubble covers the resolution cycle.
            state_r <= HZ_BR_RES;
            cnt_r   <= 3'd0;
            ctrl_r  <= CTRL_BR_RES;
          end else begin
            state_r <= HZ_BR_WAIT;
            cnt_r   <= cnt_r + 3'd1;
            ctrl_r  <= CTRL_BR_WAIT;
          end
        end

        HZ_BR_RES: begin
          state_r <= HZ_IDLE;
          cnt_r   <= 3'd0;
          if (branch_mem) begin
            ctrl_r <= CTRL_TAKEN;
          end else begin
            ctrl_r <= CTRL_NONE;
          end
        end

        default: begin
          state_r <= HZ_IDLE;
          cnt_r   <= 3'd0;
          ctrl_r  <= CTRL_NONE;
        end
      endcase
    end
  end

  assign stop_pc     = ctrl_r.stop_pc;
  assign stop_latch  = ctrl_r.stop_latch;
  assign bubble      = ctrl_r.bubble;
  assign flush_if_id = ctrl_r.flush_if_id;
  assign take_branch = ctrl_r.take_branch;
  assign busy        = ctrl_r.busy;

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_branch_hazard_ctrl
// Self-checking bench for branch_hazard_ctrl. A timeline model tracks how many
// falling edges have elapsed since a branch or load-use was accepted and
// derives the expected control vector from that age.
// Observed vector order: {stop_pc, stop_latch, bubble, flush_if_id, take_branch, busy}
// -----------------------------------------------------------------------------
module tb_branch_hazard_ctrl;

  localparam int BW = 2;
  localparam int RW = 5;
`ifdef HAZARD_LOAD_USE_EN
  localparam bit LU_EN = 1'b1;
`else
  localparam bit LU_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [5:0]    opcode_id = 6'd0;
  logic [RW-1:0] rs_id = 5'd0;
  logic [RW-1:0] rt_id = 5'd0;
  logic          mem_read_ex = 1'b0;
  logic [RW-1:0] rt_ex = 5'd0;
  logic          branch_mem = 1'b0;
  logic          stop_pc, stop_latch, bubble, flush_if_id, take_branch, busy;

  int total = 0;
  int bad   = 0;

  // Reference timeline state
  int   br_age = -1;     // edges since branch accepted, -1 when none in flight
  bit   lu_open = 1'b0;  // a load-use stall cycle is in progress
  logic [5:0] exp_v = 6'd0;

  branch_hazard_ctrl #(
    .BR_WAIT (BW),
    .REG_W   (RW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .opcode_id   (opcode_id),
    .rs_id       (rs_id),
    .rt_id       (rt_id),
    .mem_read_ex (mem_read_ex),
    .rt_ex       (rt_ex),
    .branch_mem  (branch_mem),
    .stop_pc     (stop_pc),
    .stop_latch  (stop_latch),
    .bubble      (bubble),
    .flush_if_id (flush_if_id),
    .take_branch (take_branch),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [5:0] opc, input logic [4:0] rs, input logic [4:0] rt,
                       input logic mr, input logic [4:0] rte, input logic bm);
    opcode_id   = opc;
    rs_id       = rs;
    rt_id       = rt;
    mem_read_ex = mr;
    rt_ex       = rte;
    branch_mem  = bm;
  endtask

  // Expected outputs after the coming falling edge, from the current inputs.
  task automatic model_edge();
    bit lu, br;
    bit s_pc, s_lat, s_bub, s_fl, s_tk, s_busy;
    lu = LU_EN && mem_read_ex && (rt_ex != 5'd0) && ((rt_ex == rs_id) || (rt_ex == rt_id));
    br = (opcode_id == 6'b000100) || (opcode_id == 6'b000101);
    {s_pc, s_lat, s_bub, s_fl, s_tk, s_busy} = 6'b000000;
    if (!rst) begin
      br_age  = -1;
      lu_open = 1'b0;
    end else if (lu_open) begin
      lu_open = 1'b0;
    end else if (br_age >= 0) begin
      br_age++;
      if (br_age < BW) begin
        s_pc = 1'b1; s_bub = 1'b1; s_busy = 1'b1;
      end else if (br_age == BW) begin
        s_bub = 1'b1; s_busy = 1'b1;
      end else begin
        s_tk   = branch_mem;
        s_fl   = branch_mem;
        br_age = -1;
      end
    end else if (lu) begin
      lu_open = 1'b1;
      s_pc = 1'b1; s_lat = 1'b1; s_bub = 1'b1; s_busy = 1'b1;
    end else if (br) begin
      br_age = 0;
      s_pc = 1'b1; s_bub = 1'b1; s_busy = 1'b1;
    end
    exp_v = {s_pc, s_lat, s_bub, s_fl, s_tk, s_busy};
  endtask

  task automatic check(input string tag, input logic [5:0] want);
    logic [5:0] obs;
    obs = {stop_pc, stop_latch, bubble, flush_if_id, take_branch, busy};
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b (t=%0t)", tag, obs, want, $time);
    end
  endtask

  // One controller cycle: model, falling edge, compare shortly after.
  task automatic step(input string tag);
    model_edge();
    @(negedge clk);
    #1;
    check(tag, exp_v);
  endtask

  initial begin
    // Reset held with random inputs
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(6'($urandom_range(0, 63)), 5'($urandom), 5'($urandom), 1'($urandom),
            5'($urandom), 1'($urandom));
      step("reset_hold");
    end
    drive(6'b000000, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    rst = 1'b1;
    step("after_release0");
    step("after_release1");

    // Load-use hit on rs, then same with rt_ex = 0
    drive(6'b000000, 5'd5, 5'd1, 1'b1, 5'd5, 1'b0);
    step("lu_hit");
    drive(6'b000000, 5'd5, 5'd1, 1'b0, 5'd5, 1'b0);
    step("lu_release");
    step("lu_idle");
    drive(6'b000000, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
    step("lu_r0");
    drive(6'b000000, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    step("lu_r0_idle");

    // Taken beq
    drive(6'b000100, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0);
    step("beq_detect");
    drive(6'b000000, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0);
    step("beq_wait");
    step("beq_res");
    drive(6'b000000, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1);
    step("beq_taken");
    drive(6'b000000, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0);
    step("beq_after");

    // Not-taken bne with branch_mem pulsed while still waiting
    drive(6'b000101, 5'd3, 5'd4, 1'b0, 5'd0, 1'b0);
    step("bne_detect");
    drive(6'b000101, 5'd3, 5'd4, 1'b0, 5'd0, 1'b1);
    step("bne_wait_bm");
    step("bne_res");
    drive(6'b000000, 5'd3, 5'd4, 1'b0, 5'd0, 1'b0);
    step("bne_nottaken");
    step("bne_after");

    // Branch in ID together with a load-use hit on rt_id
    drive(6'b000100, 5'd1, 5'd7, 1'b1, 5'd7, 1'b0);
    step("prio_first");
    drive(6'b000100, 5'd1, 5'd7, 1'b0, 5'd7, 1'b0);
    for (int i = 0; i < BW + 3; i++) begin
      if (i == BW + 1) branch_mem = 1'b1;
      else branch_mem = 1'b0;
      step("prio_seq");
    end

    // Back-to-back branches held in ID
    drive(6'b000100, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1);
    for (int i = 0; i < 2 * (BW + 2); i++) begin
      step("b2b");
    end
    drive(6'b000000, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < BW + 2; i++) begin
      step("b2b_drain");
    end

    // Reset in the middle of BR_WAIT_S
    drive(6'b000100, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    step("mid_detect");
    drive(6'b000000, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_async_drop", 6'b000000);
    step("mid_hold");
    rst = 1'b1;
    for (int i = 0; i < BW + 2; i++) begin
      step("mid_no_take");
    end

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [5:0] opc;
      if ($urandom_range(0, 9) < 4) opc = ($urandom_range(0, 1) != 0) ? 6'b000100 : 6'b000101;
      else opc = 6'($urandom_range(0, 63));
      drive(opc, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      rst = ($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1;
      step("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
